// File: rtl/riscvboy_dbus_ic_if.sv
// rtl/riscvboy_dbus_ic_if.sv - core data port and slave fabric signals of the data-bus interconnect
// master: the interconnect's view; slave: the core plus slave fabric that surround it.
interface riscvboy_dbus_ic_if #(
  parameter int NUM_SLV = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
);
  logic                  i_m_ren;
  logic                  i_m_wen;
  logic [AW-1:0]         i_m_addr;
  logic [DW-1:0]         i_m_wdata;
  logic [DW/8-1:0]       i_m_wstrb;
  logic [DW-1:0]         o_m_rdata;
  logic                  o_m_ready;
  logic                  o_m_err;
  logic [NUM_SLV-1:0]    o_s_req;
  logic                  o_s_we;
  logic [AW-1:0]         o_s_addr;
  logic [DW-1:0]         o_s_wdata;
  logic [DW/8-1:0]       o_s_wstrb;
  logic [NUM_SLV-1:0]    i_s_ack;
  logic [NUM_SLV*DW-1:0] i_s_rdata;

  modport master (
    input  i_m_ren, i_m_wen, i_m_addr, i_m_wdata, i_m_wstrb, i_s_ack, i_s_rdata,
    output o_m_rdata, o_m_ready, o_m_err, o_s_req, o_s_we, o_s_addr, o_s_wdata, o_s_wstrb
  );

  modport slave (
    output i_m_ren, i_m_wen, i_m_addr, i_m_wdata, i_m_wstrb, i_s_ack, i_s_rdata,
    input  o_m_rdata, o_m_ready, o_m_err, o_s_req, o_s_we, o_s_addr, o_s_wdata, o_s_wstrb
  );
endinterface

// File: rtl/riscvboy_dbus_ic.sv
// rtl/riscvboy_dbus_ic.sv - data-bus interconnect: region decode, req/ack handshake, error reporting
// Optional slave-acknowledge timeout is built when RISCVBOY_DBUS_TIMEOUT_EN is defined.
module riscvboy_dbus_ic #(
  parameter int NUM_SLV    = 4,
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int REGION_LSB = 16,
  parameter int TIMEOUT    = 15
) (
  input logic                clk_sys,
  input logic                rst_n,
  riscvboy_dbus_ic_if.master bus
);
  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int HI    = REGION_LSB + SEL_W;
  localparam logic [SEL_W:0] NUM_SLV_W = (SEL_W+1)'(NUM_SLV);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

  state_t             state;
  logic [SEL_W-1:0]   idx_q;
  logic [SEL_W-1:0]   dec_idx;
  logic [AW-1:0]      addr_hi;
  logic [NUM_SLV-1:0] dec_onehot;
  logic               dec_ok;
  logic               m_req;

`ifdef RISCVBOY_DBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  logic [CNT_W-1:0] wait_cnt;
`endif

  // Any set bit above the select field, or an index past the last slave, is unmapped.
  always_comb begin
    dec_idx    = bus.i_m_addr[REGION_LSB +: SEL_W];
    addr_hi    = bus.i_m_addr >> HI;
    dec_ok     = ({1'b0, dec_idx} < NUM_SLV_W) && (addr_hi == '0);
    dec_onehot = '0;
    dec_onehot[dec_idx] = 1'b1;
    m_req      = bus.i_m_ren | bus.i_m_wen;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      idx_q         <= '0;
      bus.o_s_req   <= '0;
      bus.o_s_we    <= 1'b0;
      bus.o_s_addr  <= '0;
      bus.o_s_wdata <= '0;
      bus.o_s_wstrb <= '0;
      bus.o_m_rdata <= '0;
      bus.o_m_ready <= 1'b0;
      bus.o_m_err   <= 1'b0;
`ifdef RISCVBOY_DBUS_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          bus.o_m_ready <= 1'b0;
          bus.o_m_err   <= 1'b0;
          if (m_req && dec_ok) begin
            state         <= S_WAIT;
            idx_q         <= dec_idx;
            bus.o_s_req   <= dec_onehot;
            bus.o_s_we    <= bus.i_m_wen;
            bus.o_s_addr  <= bus.i_m_addr;
            bus.o_s_wdata <= bus.i_m_wdata;
            bus.o_s_wstrb <= bus.i_m_wstrb;
`ifdef RISCVBOY_DBUS_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
          end else if (m_req) begin
            state         <= S_ERR;
            bus.o_m_ready <= 1'b1;
            bus.o_m_err   <= 1'b1;
            bus.o_m_rdata <= '0;
          end
        end
        S_WAIT: begin
          // Only the selected slave's acknowledge counts; it also beats a same-cycle timeout.
          if (bus.i_s_ack[idx_q]) begin
            state         <= S_DONE;
            bus.o_s_req   <= '0;
            bus.o_m_ready <= 1'b1;
            bus.o_m_err   <= 1'b0;
            bus.o_m_rdata <= bus.o_s_we ? '0 : bus.i_s_rdata[idx_q*DW +: DW];
          end
`ifdef RISCVBOY_DBUS_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            state         <= S_ERR;
            wait_cnt      <= CNT_MAX;
            bus.o_s_req   <= '0;
            bus.o_m_ready <= 1'b1;
            bus.o_m_err   <= 1'b1;
            bus.o_m_rdata <= '0;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_DONE, S_ERR: begin
          state         <= S_IDLE;
          bus.o_m_ready <= 1'b0;
          bus.o_m_err   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/riscvboy_dbus_ic.md
# riscvboy_dbus_ic

- Parametrised data-bus interconnect between the core data port and `NUM_SLV` memory-mapped slaves (dmem, timer, UART, GPIO, …).
- Replaces the fixed single-dmem hookup with:
  - address-region decode;
  - a request/acknowledge handshake that supports multi-cycle slaves;
  - decode-error and optional timeout-error reporting back to the core.
- Sits in the top level between the core's data port and the slave fabric; one transaction is outstanding at a time.

## Interface
Parameters:
- `NUM_SLV`, 4: number of slave ports (1–16).
- `AW`, 32: address width.
- `DW`, 32: data width.
- `REGION_LSB`, 16: lowest address bit of the slave-select field.
- `TIMEOUT`, 15: maximum wait cycles for a slave acknowledge (1–255).

Ports:
- `clk_sys` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `i_m_ren` input 1: master read request, level.
- `i_m_wen` input 1: master write request, level.
- `i_m_addr` input AW: master byte address.
- `i_m_wdata` input DW: master write data.
- `i_m_wstrb` input DW/8: byte enables for writes.
- `o_m_rdata` output DW: read data; valid while `o_m_ready` is high.
- `o_m_ready` output 1: one-cycle transaction-complete pulse.
- `o_m_err` output 1: error flag; qualified by `o_m_ready`.
- `o_s_req` output NUM_SLV: one-hot slave request.
- `o_s_we` output 1: write flag to the selected slave.
- `o_s_addr` output AW: registered address.
- `o_s_wdata` output DW: registered write data.
- `o_s_wstrb` output DW/8: registered byte enables.
- `i_s_ack` input NUM_SLV: per-slave acknowledge.
- `i_s_rdata` input NUM_SLV*DW: concatenated slave read data; slave k occupies `[k*DW +: DW]`.

## Operation
- `SEL_W` = max(1, clog2(NUM_SLV)).
- Slave index is `i_m_addr[REGION_LSB +: SEL_W]`.
- A decode error occurs if either:
  - the index is ≥ `NUM_SLV`; or
  - any address bit above `REGION_LSB+SEL_W-1` is nonzero.
- `i_m_wen` has priority: if `i_m_wen` and `i_m_ren` are both high, the transaction is a write.
- The master holds request, address and data stable until it sees `o_m_ready`.
- FSM states: IDLE, WAIT, DONE, ERR.
- IDLE:
  - If `i_m_ren|i_m_wen` and the decode is valid: register addr, wdata, wstrb, we and index; set `o_s_req[idx]`; go to WAIT.
  - If the decode is invalid: go to ERR.
  - Otherwise stay in IDLE.
- WAIT:
  - `o_s_req[idx]` stays high.
  - On `i_s_ack[idx]`: capture the `i_s_rdata` slice into `o_m_rdata` (0 for writes); clear `o_s_req`; go to DONE.
  - Acknowledges from non-selected slaves are ignored.
  - The wait counter increments each WAIT cycle without an acknowledge.
- DONE: `o_m_ready`=1, `o_m_err`=0; go to IDLE.
- ERR: `o_m_ready`=1, `o_m_err`=1, `o_m_rdata`=0; go to IDLE.
- Acknowledges arriving in IDLE, DONE or ERR are ignored.
- Reset values: state IDLE; `o_s_req`=0; `o_s_we`=0; `o_s_addr`, `o_s_wdata`, `o_s_wstrb`, `o_m_rdata`=0; `o_m_ready`=0; `o_m_err`=0; counter=0.
- Asserting `rst_n` low mid-transaction drops `o_s_req` immediately (asynchronously); no completion pulse is issued.

## Timing
- Zero-wait slave (acknowledge in the first WAIT cycle):
  - Request seen at edge n → `o_s_req` high in cycle n+1.
  - Acknowledge sampled at edge n+1 → `o_m_ready` high in cycle n+2.
- Each wait state a slave inserts adds one cycle.
- Decode error: `o_m_ready`/`o_m_err` high in cycle n+1.
- The FSM returns to IDLE after every completion, so the earliest new request is accepted one cycle after the `o_m_ready` cycle.
- Peak rate is one transaction per 3 cycles.
- The wait counter is `clog2(TIMEOUT+1)` bits, cleared on IDLE→WAIT, and saturates.

## Configuration
- `RISCVBOY_DBUS_TIMEOUT_EN` defined:
  - In WAIT, once the counter reaches `TIMEOUT` with no acknowledge, clear `o_s_req` and go to ERR.
  - An acknowledge in the same cycle the counter reaches `TIMEOUT` wins: go to DONE.
- Undefined:
  - The counter logic is not built.
  - WAIT persists until an acknowledge arrives.
  - `o_m_err` is asserted only for decode errors.

## Test plan
- Read from slave 0 at `0x0000_0010`, zero-wait acknowledge, rdata `0x1234_5678` → `o_s_req`=`4'b0001` for 1 cycle; `o_m_ready` 2 cycles after request; `o_m_rdata`=`0x1234_5678`; `o_m_err`=0.
- Write to `0x0002_0004` (slave 2), wstrb `4'b0011`, acknowledge after 3 wait cycles → `o_s_req`=`4'b0100` for 4 cycles; `o_s_we`=1; `o_s_wstrb`=`4'b0011`; `o_m_ready` 5 cycles after request; `o_m_rdata`=0.
- Read at `0x0100_0000` (upper bits set) → `o_m_ready`=1 and `o_m_err`=1 in cycle n+1; `o_s_req` never asserted.
- With `RISCVBOY_DBUS_TIMEOUT_EN` and `TIMEOUT`=15, slave 1 never acknowledges → `o_s_req[1]` high for 15 cycles, then cleared; `o_m_err` pulse in the next cycle. Repeat with the acknowledge in the 15th cycle → DONE, `o_m_err`=0.
- Simultaneous `i_m_ren`/`i_m_wen`; a stray `i_s_ack[3]` during a slave-0 WAIT; `rst_n` low in WAIT → treated as a write; the stray acknowledge is ignored; all outputs return to 0 within the reset assertion with no `o_m_ready` pulse.
